// File: rtl/reset_sequencer_pkg.sv
// reset_pkg: shared definitions for the reset sequencer.
//   - state_e         : FSM state encoding (WAIT/HOLD/RUN), also driven on state_o
//   - LOSS_CNT_BITS   : width of the saturating ready-loss counter
//   - STAGE_PACK_MAX  : widest packed STAGE_HOLD vector the extraction helper accepts
//   - stage_hold()    : pulls one stage's release count out of the packed vector
package reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int LOSS_CNT_BITS  = 8;
  localparam int STAGE_PACK_MAX = 1024;

  // Returns stage idx of a packed vector whose fields are cnt_bits wide
  // (cnt_bits <= 32). Only ever evaluated at elaboration time.
  function automatic logic [31:0] stage_hold(input logic [STAGE_PACK_MAX-1:0] pk,
                                             input int idx,
                                             input int cnt_bits);
    logic [31:0] mask;
    if (cnt_bits >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << cnt_bits) - 32'd1;
    end
    return 32'(pk >> (idx * cnt_bits)) & mask;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: ready/soft-reset requests in, stage resets and status out.
//   ready_i          : asynchronous ready/lock levels (NUM_READY bits)
//   soft_reset       : synchronous soft-reset request
//   reset_o          : active-high stage resets (NUM_STAGES bits)
//   state_o          : current sequencer state
//   soft_busy_o      : soft-reset delay pending
//   ready_loss_cnt_o : saturating ready-loss count
// master = the side issuing requests, slave = the sequencer.
interface reset_sequencer_if
  import reset_pkg::*;
#(
  parameter int NUM_READY  = 4,
  parameter int NUM_STAGES = 2
);
  logic [NUM_READY-1:0]     ready_i;
  logic                     soft_reset;
  logic [NUM_STAGES-1:0]    reset_o;
  logic [1:0]               state_o;
  logic                     soft_busy_o;
  logic [LOSS_CNT_BITS-1:0] ready_loss_cnt_o;

  modport master (
    output ready_i, soft_reset,
    input  reset_o, state_o, soft_busy_o, ready_loss_cnt_o
  );

  modport slave (
    input  ready_i, soft_reset,
    output reset_o, state_o, soft_busy_o, ready_loss_cnt_o
  );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with asynchronous active-low clear.
//   clock_i   : destination clock
//   reset_n_i : asynchronous active-low clear (both flops to 0)
//   d_i       : asynchronous input level
//   q_o       : synchronised level, two edges of latency
module sync_2ff (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous level
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-stage reset release gated by debounced ready inputs.
//   clock_i   : fabric clock
//   reset_n_i : asynchronous active-low reset
//   sif       : reset_sequencer_if.slave (ready_i, soft_reset in; reset_o,
//               state_o, soft_busy_o, ready_loss_cnt_o out, all registered)
// Stages are released in order of their STAGE_HOLD counts once all ready
// inputs have been stable for READY_FILTER cycles; a soft reset re-runs the
// release sequence after SOFT_DELAY cycles without re-running the filter.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int                             NUM_READY    = 4,
  parameter int                             NUM_STAGES   = 2,
  parameter int                             CNT_BITS     = 22,
  parameter logic [NUM_STAGES*CNT_BITS-1:0] STAGE_HOLD   = {22'd4194303, 22'd31},
  parameter int                             READY_FILTER = 16,
  parameter int                             SOFT_DELAY   = 1023
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  reset_sequencer_if.slave  sif
);
  localparam int FILT_BITS = $clog2(READY_FILTER + 1);
  localparam int DLY_BITS  = $clog2(SOFT_DELAY + 1);
  localparam logic [FILT_BITS-1:0] FILT_TARGET = FILT_BITS'(READY_FILTER);
  localparam logic [DLY_BITS-1:0]  DLY_LOAD    = DLY_BITS'(SOFT_DELAY);
  localparam logic [CNT_BITS-1:0]  HOLD_LAST   =
    CNT_BITS'(stage_hold(STAGE_PACK_MAX'(STAGE_HOLD), NUM_STAGES - 1, CNT_BITS));

  // Parameter sanity, evaluated at elaboration
  if (CNT_BITS < 1 || CNT_BITS > 32) begin : g_bad_cnt_bits
    $fatal(1, "reset_sequencer: CNT_BITS must be 1..32");
  end
  if (NUM_STAGES * CNT_BITS > STAGE_PACK_MAX) begin : g_bad_pack
    $fatal(1, "reset_sequencer: STAGE_HOLD too wide");
  end
  if ((64'(HOLD_LAST) >> CNT_BITS) != 64'd0) begin : g_bad_range
    $fatal(1, "reset_sequencer: last STAGE_HOLD does not fit CNT_BITS");
  end
  if (READY_FILTER < 1) begin : g_bad_filter
    $fatal(1, "reset_sequencer: READY_FILTER must be >= 1");
  end
  if (SOFT_DELAY < 2) begin : g_bad_delay
    $fatal(1, "reset_sequencer: SOFT_DELAY must be >= 2");
  end

  logic [NUM_READY-1:0]     ready_sync;
  logic                     ready_all;
  logic [NUM_STAGES-1:0]    hold_lt;
  logic [FILT_BITS-1:0]     filt_q, filt_d;
  logic [DLY_BITS-1:0]      dly_q, dly_d;
  logic                     soft_start_q, soft_start_d;
  logic                     busy_q;
  state_e                   state_q;
  logic [CNT_BITS-1:0]      cnt_q;
  logic [NUM_STAGES-1:0]    reset_q;
  logic [LOSS_CNT_BITS-1:0] loss_q;

  for (genvar g = 0; g < NUM_READY; g++) begin : g_sync
    sync_2ff u_sync (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .d_i       (sif.ready_i[g]),
      .q_o       (ready_sync[g])
    );
  end

  assign ready_all = &ready_sync;

  // Per-stage release compare plus ordering/range checks on the hold counts
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    localparam logic [CNT_BITS-1:0] HOLD_G =
      CNT_BITS'(stage_hold(STAGE_PACK_MAX'(STAGE_HOLD), g, CNT_BITS));
    assign hold_lt[g] = (cnt_q < HOLD_G);
    if (HOLD_G == {CNT_BITS{1'b0}}) begin : g_bad_zero
      $fatal(1, "reset_sequencer: STAGE_HOLD entries must be >= 1");
    end
    if (g > 0) begin : g_order
      if (HOLD_G < CNT_BITS'(stage_hold(STAGE_PACK_MAX'(STAGE_HOLD), g - 1, CNT_BITS))) begin : g_bad_order
        $fatal(1, "reset_sequencer: STAGE_HOLD must be nondecreasing");
      end
    end
  end

  // Next-state for the ready filter and the soft-reset delay
  always_comb begin
    filt_d       = filt_q;
    dly_d        = dly_q;
    soft_start_d = 1'b0;
    if (!ready_all) begin
      filt_d = {FILT_BITS{1'b0}};
    end else if (filt_q != FILT_TARGET) begin
      filt_d = filt_q + FILT_BITS'(1);
    end else begin
      filt_d = filt_q;
    end
    // A request while already pending simply reloads, so only one restart occurs
    if (sif.soft_reset) begin
      dly_d = DLY_LOAD;
    end else if (dly_q != {DLY_BITS{1'b0}}) begin
      dly_d = dly_q - DLY_BITS'(1);
    end else begin
      dly_d = dly_q;
    end
    if (dly_q == DLY_BITS'(1) && !sif.soft_reset) begin
      soft_start_d = 1'b1;
    end else begin
      soft_start_d = 1'b0;
    end
  end

  // Filter, delay and soft-start registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      filt_q       <= {FILT_BITS{1'b0}};
      dly_q        <= {DLY_BITS{1'b0}};
      soft_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      dly_q        <= dly_d;
      soft_start_q <= soft_start_d;
      busy_q       <= (dly_d != {DLY_BITS{1'b0}});
    end
  end

  // Sequencer FSM: ready loss beats soft start beats the normal transition
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_WAIT;
      cnt_q   <= {CNT_BITS{1'b0}};
      reset_q <= {NUM_STAGES{1'b1}};
      loss_q  <= {LOSS_CNT_BITS{1'b0}};
    end else if (!ready_all) begin
      state_q <= ST_WAIT;
      cnt_q   <= {CNT_BITS{1'b0}};
      reset_q <= {NUM_STAGES{1'b1}};
      if ((state_q == ST_HOLD || state_q == ST_RUN) && loss_q != {LOSS_CNT_BITS{1'b1}}) begin
        loss_q <= loss_q + LOSS_CNT_BITS'(1);
      end
    end else if (soft_start_q && state_q != ST_WAIT) begin
      state_q <= ST_HOLD;
      cnt_q   <= {CNT_BITS{1'b0}};
      reset_q <= {NUM_STAGES{1'b1}};
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_q   <= {CNT_BITS{1'b0}};
          reset_q <= {NUM_STAGES{1'b1}};
          if (filt_q == FILT_TARGET) begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          reset_q <= hold_lt;
          // Counter stops at the last stage's count so it can never wrap
          if (cnt_q == HOLD_LAST) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        ST_RUN: begin
          reset_q <= {NUM_STAGES{1'b0}};
        end
        default: begin
          state_q <= ST_WAIT;
          cnt_q   <= {CNT_BITS{1'b0}};
          reset_q <= {NUM_STAGES{1'b1}};
        end
      endcase
    end
  end

  assign sif.reset_o          = reset_q;
  assign sif.state_o          = state_q;
  assign sif.soft_busy_o      = busy_q;
  assign sif.ready_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed self-checking bench for reset_sequencer with
// STAGE_HOLD = {20,10,5}, READY_FILTER = 4, SOFT_DELAY = 16.
module tb_reset_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reset_sequencer_if #(.NUM_READY(4), .NUM_STAGES(3)) sif ();

  reset_sequencer #(
    .NUM_READY    (4),
    .NUM_STAGES   (3),
    .CNT_BITS     (8),
    .STAGE_HOLD   ({8'd20, 8'd10, 8'd5}),
    .READY_FILTER (4),
    .SOFT_DELAY   (16)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .sif       (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge at which HOLD was entered.
  task automatic check_release(input string tag);
    repeat (5) tick();
    chk({tag, " rst@H+5"}, 32'(sif.reset_o), 32'h7);
    tick();
    chk({tag, " rst@H+6"}, 32'(sif.reset_o), 32'h6);
    repeat (4) tick();
    chk({tag, " rst@H+10"}, 32'(sif.reset_o), 32'h6);
    tick();
    chk({tag, " rst@H+11"}, 32'(sif.reset_o), 32'h4);
    repeat (9) tick();
    chk({tag, " rst@H+20"}, 32'(sif.reset_o), 32'h4);
    chk({tag, " state@H+20"}, 32'(sif.state_o), 32'd1);
    tick();
    chk({tag, " rst@H+21"}, 32'(sif.reset_o), 32'h0);
    chk({tag, " state@H+21"}, 32'(sif.state_o), 32'd2);
  endtask

  // Called with ready_i all-high and the next edge being edge 0.
  task automatic check_powerup(input string tag);
    repeat (6) tick();
    chk({tag, " wait@e5"}, 32'(sif.state_o), 32'd0);
    chk({tag, " rst@e5"}, 32'(sif.reset_o), 32'h7);
    tick();
    chk({tag, " hold@e6"}, 32'(sif.state_o), 32'd1);
    chk({tag, " rst@e6"}, 32'(sif.reset_o), 32'h7);
    check_release(tag);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    sif.ready_i    = 4'h0;
    sif.soft_reset = 1'b0;

    // Reset state and power-up
    #12;
    chk("reset rst_o", 32'(sif.reset_o), 32'h7);
    chk("reset state", 32'(sif.state_o), 32'd0);
    chk("reset busy", 32'(sif.soft_busy_o), 32'd0);
    chk("reset loss", 32'(sif.ready_loss_cnt_o), 32'd0);
    sif.ready_i = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    check_powerup("powerup");
    chk("powerup loss", 32'(sif.ready_loss_cnt_o), 32'd0);

    // Single soft reset pulse in RUN
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    chk("soft busy@n", 32'(sif.soft_busy_o), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("soft busy", 32'(sif.soft_busy_o), 32'd1);
    end
    tick();
    chk("soft busy@n+16", 32'(sif.soft_busy_o), 32'd0);
    chk("soft rst@n+16", 32'(sif.reset_o), 32'h0);
    chk("soft state@n+16", 32'(sif.state_o), 32'd2);
    tick();
    chk("soft rst@n+17", 32'(sif.reset_o), 32'h7);
    chk("soft state@n+17", 32'(sif.state_o), 32'd1);
    check_release("soft");

    // Re-asserted soft reset pushes the restart out, single restart
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    repeat (7) tick();
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    repeat (9) tick();
    chk("dbl state@n+17", 32'(sif.state_o), 32'd2);
    chk("dbl rst@n+17", 32'(sif.reset_o), 32'h0);
    repeat (7) tick();
    chk("dbl rst@n+24", 32'(sif.reset_o), 32'h0);
    chk("dbl busy@n+24", 32'(sif.soft_busy_o), 32'd0);
    tick();
    chk("dbl rst@n+25", 32'(sif.reset_o), 32'h7);
    chk("dbl state@n+25", 32'(sif.state_o), 32'd1);
    check_release("dbl");
    repeat (20) tick();
    chk("dbl single state", 32'(sif.state_o), 32'd2);
    chk("dbl single rst", 32'(sif.reset_o), 32'h0);

    // Ready loss in RUN
    sif.ready_i = 4'hE;
    tick();
    chk("loss rst@1", 32'(sif.reset_o), 32'h0);
    tick();
    chk("loss rst@2", 32'(sif.reset_o), 32'h0);
    chk("loss state@2", 32'(sif.state_o), 32'd2);
    tick();
    chk("loss rst@3", 32'(sif.reset_o), 32'h7);
    chk("loss state@3", 32'(sif.state_o), 32'd0);
    chk("loss cnt", 32'(sif.ready_loss_cnt_o), 32'd1);
    sif.ready_i = 4'hF;
    check_powerup("restore");

    // Async reset mid-HOLD with a soft reset pending
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    repeat (17) tick();
    repeat (3) tick();
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    tick();
    chk("pre-arst state", 32'(sif.state_o), 32'd1);
    chk("pre-arst busy", 32'(sif.soft_busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst rst_o", 32'(sif.reset_o), 32'h7);
    chk("arst state", 32'(sif.state_o), 32'd0);
    chk("arst busy", 32'(sif.soft_busy_o), 32'd0);
    chk("arst loss", 32'(sif.ready_loss_cnt_o), 32'd0);

    // Glitch rejection during WAIT
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    sif.ready_i = 4'hB;
    tick();
    sif.ready_i = 4'hF;
    repeat (6) tick();
    chk("glitch wait@e8", 32'(sif.state_o), 32'd0);
    tick();
    chk("glitch hold@e9", 32'(sif.state_o), 32'd1);
    chk("glitch loss", 32'(sif.ready_loss_cnt_o), 32'd0);
    check_release("glitch");

    // Ready drop coincident with soft_start
    sif.soft_reset = 1'b1;
    tick();
    sif.soft_reset = 1'b0;
    repeat (14) tick();
    sif.ready_i = 4'hE;
    tick();
    tick();
    chk("sim state@n+16", 32'(sif.state_o), 32'd2);
    chk("sim loss@n+16", 32'(sif.ready_loss_cnt_o), 32'd0);
    tick();
    chk("sim state@n+17", 32'(sif.state_o), 32'd0);
    chk("sim rst@n+17", 32'(sif.reset_o), 32'h7);
    chk("sim loss@n+17", 32'(sif.ready_loss_cnt_o), 32'd1);
    repeat (4) tick();
    chk("sim state later", 32'(sif.state_o), 32'd0);
    chk("sim loss later", 32'(sif.ready_loss_cnt_o), 32'd1);

    // Loss counter saturation: 300 further drops out of HOLD
    for (int i = 0; i < 300; i++) begin
      sif.ready_i = 4'hF;
      repeat (7) tick();
      sif.ready_i = 4'hE;
      repeat (3) tick();
      if (i == 99) begin
        chk("sat loss@101", 32'(sif.ready_loss_cnt_o), 32'd101);
      end
    end
    chk("sat loss", 32'(sif.ready_loss_cnt_o), 32'd255);
    chk("sat state", 32'(sif.state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
